fg_vram_arbiter: RTL and testbench
==================================

// Module: fg_vram_arbiter
// PURPOSE
// Shares the foreground plane's single-port VRAM between the pixel fetch path and a CPU write port.
// Fetch reads have priority; CPU writes are buffered in a small FIFO and drained in free cycles.
// Sits between the host bus bridge and the foreground plane VRAM, in the I_pxl_clk domain.
// PARAMETERS
// ADDR_W        11  VRAM address width (words)
// DATA_W        8   VRAM data width
// FIFO_DEPTH    4   CPU write FIFO entries, power of two, >=2
// STARVE_LIMIT  16  consecutive denied write cycles before a forced write slot (guard only)
// PORTS
// I_pxl_clk       in   1       pixel clock, all logic on rising edge
// I_rst_n         in   1       reset, asynchronous, active-low
// I_fetch_req     in   1       pixel fetch read request
// I_fetch_addr    in   ADDR_W  fetch address
// O_fetch_gnt     out  1       fetch request accepted this cycle
// O_fetch_valid   out  1       fetch data valid
// O_fetch_data    out  DATA_W  fetch read data
// I_cpu_wr_valid  in   1       CPU write offered
// O_cpu_wr_ready  out  1       FIFO can accept (push when valid & ready)
// I_cpu_addr      in   ADDR_W  CPU write address
// I_cpu_wdata     in   DATA_W  CPU write data
// O_vram_ce       out  1       VRAM chip enable (registered)
// O_vram_wre      out  1       VRAM write enable (registered)
// O_vram_ad       out  ADDR_W  VRAM address (registered)
// O_vram_din      out  DATA_W  VRAM write data (registered)
// I_vram_dout     in   DATA_W  VRAM read data, one cycle after ce
// BEHAVIOUR
// - Reset: all outputs 0 except O_cpu_wr_ready=1 after the first clock once reset is released; FIFO emptied; valid pipe and starve counter cleared.
// - Slot decision each cycle N: FETCH if I_fetch_req & O_fetch_gnt; else WRITE if FIFO non-empty; else IDLE.
// - FETCH: VRAM regs load ce=1, wre=0, ad=fetch_addr at edge N; O_fetch_valid=1 and O_fetch_data=I_vram_dout
//   in cycle N+2 (registered); fixed latency 2, back-to-back fetches give back-to-back valid.
// - WRITE: pop FIFO head; VRAM regs load ce=1, wre=1, ad/din=head at edge N; O_fetch_valid=0 in cycle N+2.
// - IDLE: ce=0, wre=0; ad/din hold.
// - O_cpu_wr_ready = !full (registered count). Push+pop same cycle: count unchanged, order preserved.
// - Full: ready=0, offered write not taken. Empty: no WRITE slot. Pointers wrap mod FIFO_DEPTH.
// - Writes retire in push order; a fetch to an address with a pending write returns old data (no bypass).
// - Async reset mid-burst: in-flight fetch data discarded (no valid), queued writes lost.
// CONFIGURATION
// - FG_VRAM_STARVE_GUARD_EN defined: counter increments each cycle FIFO non-empty and slot != WRITE, clears on
//   WRITE or empty, saturates at STARVE_LIMIT. At STARVE_LIMIT, O_fetch_gnt=0 for one cycle, forcing WRITE;
//   the requester holds I_fetch_req/addr until gnt.
// - Not defined: no counter; O_fetch_gnt=1 whenever out of reset; CPU writes can starve indefinitely.
// STRUCTURE
// - Package fg_vram_pkg: slot_t enum {SLOT_IDLE, SLOT_FETCH, SLOT_WRITE}, FG_ADDR_W/FG_DATA_W defaults,
//   fetch latency constant FG_FETCH_LAT=2.
// - Sub-module fg_wr_fifo: sync FIFO (push/pop/full/empty/head), count-based full/empty.
// - Top holds slot decision, VRAM output regs, 2-stage valid pipe, optional starve counter.
// TESTING
// - Reset released, no traffic: ce=0, valid=0, ready=1, gnt=1 throughout.
// - Fetch addr 0x010 with VRAM[0x010]=0xA5 -> valid=1, data=0xA5 exactly 2 cycles after request.
// - 4 CPU writes (0x020..0x023 = 0x11..0x44) during continuous fetch -> ready=0 after 4th; drain in order once
//   fetch drops, 4 WRITE slots, readback matches.
// - Push and pop same cycle at count=2 -> count stays 2, ready stays 1, data order intact.
// - Guard on, STARVE_LIMIT=16, one queued write, fetch held high -> gnt=0 for one cycle at cycle 16, write issued.
// - Reset asserted one cycle after fetch issue -> no valid pulse, FIFO empty, ready=1 after release.

Source files
------------

// File: rtl/fg_vram_pkg.sv
// Shared types and defaults for the foreground plane VRAM arbiter.
// Build option: FG_VRAM_STARVE_GUARD_EN enables the CPU write starvation guard.
package fg_vram_pkg;

  localparam int FG_ADDR_W    = 11;
  localparam int FG_DATA_W    = 8;
  localparam int FG_FETCH_LAT = 2;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_FETCH,
    SLOT_WRITE
  } slot_t;

endpackage

// File: rtl/fg_wr_fifo.sv
// Small synchronous FIFO buffering CPU writes to the foreground VRAM.
// Count-based full/empty; depth must be a power of two.
module fg_wr_fifo
  import fg_vram_pkg::*;
#(
  parameter int W     = FG_ADDR_W + FG_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic         I_pxl_clk,
  input  logic         I_rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge I_pxl_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fg_vram_arbiter.sv
// Shares the foreground VRAM between pixel fetch (priority) and buffered CPU writes.
// Build option: FG_VRAM_STARVE_GUARD_EN forces a write slot after STARVE_LIMIT denials.
module fg_vram_arbiter
  import fg_vram_pkg::*;
#(
  parameter int ADDR_W       = FG_ADDR_W,
  parameter int DATA_W       = FG_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  input  logic              I_fetch_req,
  input  logic [ADDR_W-1:0] I_fetch_addr,
  output logic              O_fetch_gnt,
  output logic              O_fetch_valid,
  output logic [DATA_W-1:0] O_fetch_data,
  input  logic              I_cpu_wr_valid,
  output logic              O_cpu_wr_ready,
  input  logic [ADDR_W-1:0] I_cpu_addr,
  input  logic [DATA_W-1:0] I_cpu_wdata,
  output logic              O_vram_ce,
  output logic              O_vram_wre,
  output logic [ADDR_W-1:0] O_vram_ad,
  output logic [DATA_W-1:0] O_vram_din,
  input  logic [DATA_W-1:0] I_vram_dout
);

  localparam int EW = ADDR_W + DATA_W;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be >= 1");
  end

  logic                    run_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [EW-1:0]           head;
  logic                    push;
  logic                    pop;
  logic                    starve_hit;
  slot_t                   slot;
  logic [FG_FETCH_LAT-1:0] vpipe;

  // Outputs stay low in reset and rise on the first clock after release.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign O_fetch_gnt    = run_q & ~starve_hit;
  assign O_cpu_wr_ready = run_q & ~fifo_full;
  assign push           = I_cpu_wr_valid & O_cpu_wr_ready;
  assign pop            = (slot == SLOT_WRITE);

  always_comb begin
    slot = SLOT_IDLE;
    if (I_fetch_req && O_fetch_gnt) begin
      slot = SLOT_FETCH;
    end else if (!fifo_empty) begin
      slot = SLOT_WRITE;
    end
  end

  fg_wr_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .I_pxl_clk (I_pxl_clk),
    .I_rst_n   (I_rst_n),
    .push      (push),
    .pop       (pop),
    .din       ({I_cpu_addr, I_cpu_wdata}),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FG_VRAM_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q;

  assign starve_hit = (starve_q == LIMIT);

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      starve_q <= '0;
    end else if (fifo_empty || slot == SLOT_WRITE) begin
      starve_q <= '0;
    end else if (!starve_hit) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_vram_ce  <= 1'b0;
      O_vram_wre <= 1'b0;
      O_vram_ad  <= '0;
      O_vram_din <= '0;
    end else begin
      unique case (slot)
        SLOT_FETCH: begin
          O_vram_ce  <= 1'b1;
          O_vram_wre <= 1'b0;
          O_vram_ad  <= I_fetch_addr;
        end
        SLOT_WRITE: begin
          O_vram_ce  <= 1'b1;
          O_vram_wre <= 1'b1;
          O_vram_ad  <= head[EW-1:DATA_W];
          O_vram_din <= head[DATA_W-1:0];
        end
        default: begin
          O_vram_ce  <= 1'b0;
          O_vram_wre <= 1'b0;
        end
      endcase
    end
  end

  // Read data is sampled in the cycle the read is presented to the VRAM.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vpipe        <= '0;
      O_fetch_data <= '0;
    end else begin
      vpipe <= {vpipe[FG_FETCH_LAT-2:0], slot == SLOT_FETCH};
      if (vpipe[FG_FETCH_LAT-2]) begin
        O_fetch_data <= I_vram_dout;
      end
    end
  end

  assign O_fetch_valid = vpipe[FG_FETCH_LAT-1];

endmodule

// File: tb/tb_fg_vram_arbiter.sv
// Directed bench for fg_vram_arbiter with a behavioural VRAM model.
// Build option: FG_VRAM_STARVE_GUARD_EN selects the guard-enabled expectations.
module tb_fg_vram_arbiter;

`ifdef FG_VRAM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [10:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [7:0]  fetch_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        vram_ce;
  logic        vram_wre;
  logic [10:0] vram_ad;
  logic [7:0]  vram_din;
  logic [7:0]  vram_dout;

  logic [7:0]  mem [2048];
  int          vectors;
  int          miscompares;

  fg_vram_arbiter #(
    .ADDR_W       (11),
    .DATA_W       (8),
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (16)
  ) dut (
    .I_pxl_clk      (clk),
    .I_rst_n        (rst_n),
    .I_fetch_req    (fetch_req),
    .I_fetch_addr   (fetch_addr),
    .O_fetch_gnt    (fetch_gnt),
    .O_fetch_valid  (fetch_valid),
    .O_fetch_data   (fetch_data),
    .I_cpu_wr_valid (wr_valid),
    .O_cpu_wr_ready (wr_ready),
    .I_cpu_addr     (cpu_addr),
    .I_cpu_wdata    (cpu_wdata),
    .O_vram_ce      (vram_ce),
    .O_vram_wre     (vram_wre),
    .O_vram_ad      (vram_ad),
    .O_vram_din     (vram_din),
    .I_vram_dout    (vram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign vram_dout = mem[vram_ad];

  always @(posedge clk) begin
    if (vram_ce && vram_wre) begin
      mem[vram_ad] <= vram_din;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [10:0] ad,
                        input logic [7:0] din);
    chk({tag, "_ce"}, 32'(vram_ce), 32'd1);
    chk({tag, "_wre"}, 32'(vram_wre), 32'd1);
    chk({tag, "_ad"}, 32'(vram_ad), 32'(ad));
    chk({tag, "_din"}, 32'(vram_din), 32'(din));
  endtask

  task automatic push_wr(input logic [10:0] a, input logic [7:0] d);
    wr_valid  = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    tick();
    wr_valid  = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h010] = 8'hA5;
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    wr_valid   = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    tick();
    tick();

    chk("rst_ce", 32'(vram_ce), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_gnt", 32'(fetch_gnt), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("idle_ce", 32'(vram_ce), 32'd0);
      chk("idle_valid", 32'(fetch_valid), 32'd0);
      chk("idle_ready", 32'(wr_ready), 32'd1);
      chk("idle_gnt", 32'(fetch_gnt), 32'd1);
      tick();
    end

    // single fetch, latency 2
    fetch_req  = 1'b1;
    fetch_addr = 11'h010;
    chk("f_gnt", 32'(fetch_gnt), 32'd1);
    tick();
    fetch_req = 1'b0;
    chk("f_ce", 32'(vram_ce), 32'd1);
    chk("f_wre", 32'(vram_wre), 32'd0);
    chk("f_ad", 32'(vram_ad), 32'h010);
    chk("f_valid_n1", 32'(fetch_valid), 32'd0);
    tick();
    chk("f_valid_n2", 32'(fetch_valid), 32'd1);
    chk("f_data", 32'(fetch_data), 32'hA5);
    tick();
    chk("f_valid_n3", 32'(fetch_valid), 32'd0);

    // fill the FIFO under continuous fetch
    fetch_req  = 1'b1;
    fetch_addr = 11'h100;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 32'(wr_ready), 32'd1);
      push_wr(11'(11'h020 + i), 8'(8'h11 * (i + 1)));
    end
    chk("full_ready", 32'(wr_ready), 32'd0);
    chk("full_nowr", 32'(vram_wre), 32'd0);
    push_wr(11'h0FF, 8'hEE);
    chk("full_ready2", 32'(wr_ready), 32'd0);
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_wr("drain", 11'(11'h020 + i), 8'(8'h11 * (i + 1)));
    end
    tick();
    chk("drain_end_ce", 32'(vram_ce), 32'd0);
    chk("drain_ready", 32'(wr_ready), 32'd1);
    chk("rejected_wr", 32'(mem[11'h0FF]), 32'd0);

    // back-to-back readback
    for (int i = 0; i < 6; i++) begin
      fetch_req  = (i < 4);
      fetch_addr = 11'(11'h020 + i);
      tick();
      if (i >= 1) begin
        chk("rb_valid", 32'(fetch_valid), 32'((i - 1) < 4));
        if (i - 1 < 4)
          chk("rb_data", 32'(fetch_data), 32'(8'(8'h11 * i)));
      end
    end
    fetch_req = 1'b0;

    // push and pop in the same cycle at count 2
    fetch_req  = 1'b1;
    fetch_addr = 11'h100;
    push_wr(11'h030, 8'h55);
    push_wr(11'h031, 8'h66);
    fetch_req = 1'b0;
    chk("pp_ready_pre", 32'(wr_ready), 32'd1);
    push_wr(11'h032, 8'h77);
    chk_wr("pp_pop", 11'h030, 8'h55);
    chk("pp_ready", 32'(wr_ready), 32'd1);
    fetch_req = 1'b1;
    push_wr(11'h033, 8'h88);
    chk("pp_fetch_wre", 32'(vram_wre), 32'd0);
    chk("pp_ready3", 32'(wr_ready), 32'd1);
    push_wr(11'h034, 8'h99);
    chk("pp_ready4", 32'(wr_ready), 32'd0);
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_wr("pp_drain", 11'(11'h031 + i), 8'(8'h66 + 8'h11 * i));
    end
    tick();
    chk("pp_end_ce", 32'(vram_ce), 32'd0);

    // one queued write behind a held fetch
    fetch_req  = 1'b1;
    fetch_addr = 11'h100;
    push_wr(11'h040, 8'hAB);
    for (int k = 1; k <= 20; k++) begin
      chk("sv_gnt", 32'(fetch_gnt), 32'(!(GUARD && k == 17)));
      chk("sv_wre", 32'(vram_wre), 32'(GUARD && k == 18));
      tick();
    end
    fetch_req = 1'b0;
    tick();
    chk("sv_late_wre", 32'(vram_wre), 32'(!GUARD));
    tick();
    chk("sv_mem", 32'(mem[11'h040]), 32'hAB);

    // async reset with a fetch in flight and writes queued
    fetch_req  = 1'b1;
    fetch_addr = 11'h100;
    push_wr(11'h050, 8'h01);
    push_wr(11'h051, 8'h02);
    fetch_addr = 11'h010;
    tick();
    fetch_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(fetch_valid), 32'd0);
    chk("ar_ce", 32'(vram_ce), 32'd0);
    chk("ar_ready", 32'(wr_ready), 32'd0);
    chk("ar_data", 32'(fetch_data), 32'd0);
    tick();
    tick();
    chk("ar_valid2", 32'(fetch_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ar_post_ready", 32'(wr_ready), 32'd1);
      chk("ar_post_valid", 32'(fetch_valid), 32'd0);
      chk("ar_post_ce", 32'(vram_ce), 32'd0);
      tick();
    end
    chk("ar_lost0", 32'(mem[11'h050]), 32'd0);
    chk("ar_lost1", 32'(mem[11'h051]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
